// File: rtl/repadd_ctrl_if.sv
// Control/status bundle between the repeated-addition multiplier controller
// and its datapath plus requester.
interface repadd_ctrl_if;
  localparam int unsigned DATA_W = 16;

  logic              start;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              eqz;
  logic              ldA;
  logic              ldB;
  logic              clrP;
  logic              ldP;
  logic              decB;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] add_cnt;

  // Requester/datapath side
  modport master (
    output start, din_valid, din, eqz,
    input  ldA, ldB, clrP, ldP, decB, busy, done, add_cnt
  );

  // Controller side
  modport slave (
    input  start, din_valid, din, eqz,
    output ldA, ldB, clrP, ldP, decB, busy, done, add_cnt
  );
endinterface

// File: rtl/repadd_ctrl.sv
// Controller for a repeated-addition multiplier: loads A and B from a shared
// bus, then issues one add (ldP) and one decrement (decB) per multiplier count.
module repadd_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  repadd_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MUL    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] add_cnt_q;

  // State register; reset anywhere returns to IDLE, which zeroes all decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode from state plus bus inputs
  always_comb begin
    state_nxt = state;
    bus.ldA   = 1'b0;
    bus.ldB   = 1'b0;
    bus.clrP  = 1'b0;
    bus.ldP   = 1'b0;
    bus.decB  = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD_A;
          cnt_clr   = 1'b1;
        end
      end
      LOAD_A: begin
        bus.busy = 1'b1;
        bus.ldA  = bus.din_valid;
        if (bus.din_valid) begin
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        bus.busy = 1'b1;
        bus.ldB  = bus.din_valid;
        bus.clrP = bus.din_valid;
        // A zero multiplier skips MUL; the cleared product is already final
        if (bus.din_valid) begin
          state_nxt = (bus.din == '0) ? DONE : MUL;
        end
      end
      MUL: begin
        bus.busy = 1'b1;
        bus.ldP  = 1'b1;
        bus.decB = 1'b1;
        cnt_inc  = 1'b1;
        // eqz means this is the last count, so this cycle's add completes N adds
        if (bus.eqz) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Add counter: cleared on start accept, held after DONE until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_cnt_q <= '0;
    end else if (cnt_clr) begin
      add_cnt_q <= '0;
    end else if (cnt_inc) begin
      add_cnt_q <= add_cnt_q + CNT_W'(1);
    end
  end

  assign bus.add_cnt = add_cnt_q;

endmodule

// File: tb/tb_repadd_ctrl.sv
// Directed bench for repadd_ctrl with a small behavioural datapath attached.
module tb_repadd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  repadd_ctrl_if bus();

  repadd_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath; deliberately not reset, the next operation reloads it
  logic [15:0] a_reg = 16'd0;
  logic [15:0] b_reg = 16'd0;
  logic [15:0] p_reg = 16'd0;

  always @(posedge clk) begin
    if (bus.ldA) a_reg <= bus.din;
    if (bus.ldB) b_reg <= bus.din;
    else if (bus.decB) b_reg <= b_reg - 16'd1;
    if (bus.clrP) p_reg <= 16'd0;
    else if (bus.ldP) p_reg <= p_reg + a_reg;
  end

  assign bus.eqz = (b_reg == 16'd1);

  task automatic test_reset();
    bus.start = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = 16'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB, bus.busy, bus.done} !== 7'd0 ||
        bus.add_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ctl=%b cnt=%0d want ctl=0000000 cnt=0",
               {bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB, bus.busy, bus.done}, bus.add_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  // One full operation. Cycle 0 is the start cycle (already elapsed when pre=1).
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input int stall_a, input int stall_b, input int start_at,
                       input bit pre, input bit chain,
                       input logic [15:0] exp_prod, input logic [15:0] exp_cnt);
    int a_cyc = 1 + stall_a;
    int b_cyc = a_cyc + 1 + stall_b;
    int exp_done = b_cyc + 1 + int'(b);
    int n_lda = 0, n_ldb = 0, n_clrp = 0, n_ldp = 0, n_decb = 0;
    int done_cyc = -1;
    int cyc = 1;
    bit busy_ok = 1'b1, excl_ok = 1'b1;
    if (!pre) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.din_valid = 1'b0;
      #1;
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle_busy: got %b want 0", name, bus.busy);
      end
    end
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      bus.start = (cyc == start_at);
      bus.din_valid = (cyc == a_cyc) || (cyc >= b_cyc);
      bus.din = (cyc == a_cyc) ? a : (cyc == b_cyc) ? b : 16'hBEEF;
      #1;
      if (cyc == 1) begin
        vectors++;
        if (bus.add_cnt !== 16'd0) begin
          miscompares++;
          $display("FAIL %s add_cnt_clear: got %0d want 0", name, bus.add_cnt);
        end
      end
      n_lda  += int'(bus.ldA);
      n_ldb  += int'(bus.ldB);
      n_clrp += int'(bus.clrP);
      n_ldp  += int'(bus.ldP);
      n_decb += int'(bus.decB);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (int'(bus.ldA) + int'(bus.ldB) + int'(bus.ldP) > 1 || (bus.clrP && !bus.ldB))
        excl_ok = 1'b0;
      if (bus.done === 1'b1) done_cyc = cyc;
      cyc++;
    end
    vectors++;
    if (done_cyc != exp_done) begin
      miscompares++;
      $display("FAIL %s done_latency: got cycle %0d want %0d", name, done_cyc, exp_done);
    end
    vectors++;
    if (n_lda != 1 || n_ldb != 1 || n_clrp != 1) begin
      miscompares++;
      $display("FAIL %s load_pulses: got ldA=%0d ldB=%0d clrP=%0d want 1 1 1",
               name, n_lda, n_ldb, n_clrp);
    end
    vectors++;
    if (n_ldp != int'(b) || n_decb != int'(b)) begin
      miscompares++;
      $display("FAIL %s mul_cycles: got ldP=%0d decB=%0d want %0d", name, n_ldp, n_decb, b);
    end
    vectors++;
    if (!busy_ok || !excl_ok) begin
      miscompares++;
      $display("FAIL %s busy_excl: got busy_ok=%b excl_ok=%b want 1 1", name, busy_ok, excl_ok);
    end
    // First IDLE cycle after DONE; optionally carries the next start
    @(negedge clk);
    bus.start = chain;
    bus.din_valid = 1'b1;
    bus.din = 16'h1234;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ldA !== 1'b0 || bus.ldB !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post_idle: got busy=%b done=%b ldA=%b ldB=%b want 0 0 0 0",
               name, bus.busy, bus.done, bus.ldA, bus.ldB);
    end
    vectors++;
    if (p_reg !== exp_prod) begin
      miscompares++;
      $display("FAIL %s product: got %0d want %0d", name, p_reg, exp_prod);
    end
    vectors++;
    if (bus.add_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s add_cnt: got %0d want %0d", name, bus.add_cnt, exp_cnt);
    end
  endtask

  task automatic test_idle_ignore();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din = 16'd5;
      #1;
      vectors++;
      if ({bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB, bus.busy, bus.done} !== 7'd0 ||
          bus.add_cnt !== 16'd4) begin
        miscompares++;
        $display("FAIL idle_ignore: got ctl=%b cnt=%0d want ctl=0000000 cnt=4",
                 {bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB, bus.busy, bus.done}, bus.add_cnt);
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    bus.start = 1'b1;
    bus.din_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din_valid = 1'b1;
    bus.din = 16'd4;
    @(negedge clk);
    bus.din = 16'd10;
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.ldP !== 1'b1 || bus.add_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL rst_mid_mul_pre: got ldP=%b cnt=%0d want 1 2", bus.ldP, bus.add_cnt);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB, bus.busy, bus.done} !== 7'd0 ||
        bus.add_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_mul_async: got ctl=%b cnt=%0d want ctl=0000000 cnt=0",
               {bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB, bus.busy, bus.done}, bus.add_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release_busy: got %b want 0", bus.busy);
    end
    do_op("a4_b10_after_rst", 16'd4, 16'd10, 0, 0, 0, 1'b1, 1'b0, 16'd40, 16'd10);
  endtask

  initial begin
    test_reset();
    do_op("a3_b4", 16'd3, 16'd4, 0, 0, 0, 1'b0, 1'b0, 16'd12, 16'd4);
    test_idle_ignore();
    do_op("a7_b0", 16'd7, 16'd0, 0, 0, 0, 1'b0, 1'b0, 16'd0, 16'd0);
    do_op("a9_b1", 16'd9, 16'd1, 0, 0, 0, 1'b0, 1'b0, 16'd9, 16'd1);
    do_op("a5_b2_stall", 16'd5, 16'd2, 5, 3, 0, 1'b0, 1'b0, 16'd10, 16'd2);
    do_op("a2_b6_start_in_mul", 16'd2, 16'd6, 0, 0, 5, 1'b0, 1'b1, 16'd12, 16'd6);
    do_op("a0_b3_back_to_back", 16'd0, 16'd3, 0, 0, 0, 1'b1, 1'b0, 16'd0, 16'd3);
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/repadd_ctrl.md
REPADD_CTRL -- requirements
Module: repadd_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: start  input  1  request a new multiply; sampled in IDLE only.
REQ-004 SHALL have: din_valid  input  1  shared 16-bit operand bus carries a valid operand this cycle.
REQ-005 SHALL have: din  input  16  shared operand bus (same bus driven into the datapath); used only for the zero-multiplier check.
REQ-006 SHALL have: eqz  input  1  datapath flag, high when the multiplier counter equals 1.
REQ-007 SHALL have: ldA, ldB, clrP, ldP, decB  output  1 each  datapath controls.
REQ-008 SHALL have: busy  output  1  operation in progress, from accept of start until the DONE state is left.
REQ-009 SHALL have: done  output  1  one-cycle pulse; the product register is final.
REQ-010 SHALL have: add_cnt  output  16  number of ldP cycles issued in the current or last operation.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, MUL, DONE; state register only is clocked, and datapath controls are combinational decodes of state plus listed inputs.
REQ-012 IDLE: all controls 0, busy=0; start=1 -> LOAD_A next cycle and add_cnt cleared to 0; start=0 -> stay.
REQ-013 LOAD_A: ldA = din_valid; on din_valid=1 -> LOAD_B, else stay (unbounded stall allowed).
REQ-014 LOAD_B: ldB = clrP = din_valid; on din_valid=1 and din==0 -> DONE; on din_valid=1 and din!=0 -> MUL; else stay.
REQ-015 MUL: ldP=1 and decB=1 every cycle; add_cnt increments by 1 per MUL cycle (wraps modulo 2^16); eqz=1 in MUL -> DONE after that cycle's add, else stay.
REQ-016 Add-count rule: a multiplier of N (N>=1) SHALL produce exactly N MUL cycles, so that product register = A*N mod 2^16.
REQ-017 DONE: done=1 for exactly one cycle, all datapath controls 0, busy=1; -> IDLE unconditionally.
REQ-018 busy SHALL be 1 in LOAD_A, LOAD_B, MUL, DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored in all states except IDLE; no queuing.
REQ-020 din_valid SHALL be ignored in IDLE, MUL and DONE.
REQ-021 Multiplier 0: zero MUL cycles, product register holds 0 from clrP, add_cnt=0, done asserted one cycle after the LOAD_B accept.
REQ-022 Multiplicand 0 SHALL follow the normal path (N MUL cycles, product 0).
REQ-023 At most one of {ldA, ldB, ldP} SHALL be asserted in any cycle; clrP SHALL only coincide with ldB.
REQ-024 Latency from start accept (no stalls) to done: 3 + N cycles for N>=1; 3 cycles for N=0.
REQ-025 add_cnt SHALL hold its value after DONE until the next start is accepted.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, add_cnt=0, busy=0, done=0, all datapath controls 0, in any state including mid-MUL.
REQ-027 After rst_n deasserts, the block SHALL accept start on the first rising clk edge where rst_n is high; datapath register contents are not restored and a new operation reloads them.

Verification
REQ-028 A=3, B=4, din_valid high on the two cycles after start -> ldA 1 cycle, ldB+clrP 1 cycle, ldP/decB 4 cycles, done 1 cycle; product=12, add_cnt=4.
REQ-029 A=7, B=0 -> no ldP cycles, done 1 cycle after ldB; product=0, add_cnt=0.
REQ-030 A=9, B=1 -> exactly 1 MUL cycle (eqz high on entry); product=9, add_cnt=1.
REQ-031 din_valid held low 5 cycles in LOAD_A and 3 in LOAD_B, then A=5, B=2 -> FSM stalls, no spurious loads; product=10, busy high throughout.
REQ-032 start pulsed during MUL of A=2, B=6 -> ignored; single done, product=12; a start in the cycle after done returns to IDLE is accepted.
REQ-033 rst_n pulsed low during the 3rd MUL cycle of A=4, B=10 -> all outputs 0 immediately without clk edge; next operation A=4, B=10 yields product=40, add_cnt=10.
